// File: rtl/uart_alu_sequencer.sv
// Byte-stream command sequencer: gathers A, B and opcode bytes from the UART RX,
// drives the ALU, then returns the BUS-wide result over UART TX, LSB byte first.
module uart_alu_sequencer #(
    parameter int BUS = 8
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic [7:0]     i_rx_data,
    input  logic           i_rx_done,
    input  logic [BUS-1:0] i_alu_result,
    output logic [BUS-1:0] o_alu_a,
    output logic [BUS-1:0] o_alu_b,
    output logic [7:0]     o_alu_op,
    output logic [7:0]     o_tx_data,
    output logic           o_tx_start,
    input  logic           i_tx_done,
    output logic           o_busy
);

    if ((BUS % 8 != 0) || (BUS < 8) || (BUS > 32)) begin : g_bad_bus
        $error("uart_alu_sequencer: BUS must be a multiple of 8 in 8..32");
    end

    localparam int             NB = BUS / 8;
    localparam int             CW = $clog2(NB + 1);
    localparam logic [CW-1:0]  NBYTES = CW'(NB);
    localparam logic [CW-1:0]  LAST   = CW'(1);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [BUS-1:0]  r_alu_a;
    logic [BUS-1:0]  r_alu_b;
    logic [7:0]      r_alu_op;
    logic [BUS-1:0]  r_result_sr;
    logic [CW-1:0]   r_cnt;
    logic            w_tx_start;
    logic            w_busy;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= GET_A;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            GET_A:   if (i_rx_done) w_next = GET_B;
            GET_B:   if (i_rx_done) w_next = GET_OP;
            GET_OP:  if (i_rx_done) w_next = EXEC;
            EXEC:    w_next = SEND;
            SEND:    w_next = WAIT_TX;
            WAIT_TX: if (i_tx_done) w_next = (r_cnt == LAST) ? GET_A : SEND;
            default: w_next = GET_A;
        endcase
    end

    always_comb begin
        w_tx_start = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            EXEC:    w_busy = 1'b1;
            SEND:    begin w_busy = 1'b1; w_tx_start = 1'b1; end
            WAIT_TX: w_busy = 1'b1;
            default: ;
        endcase
    end

    // Operands persist across commands; only a reset or a new byte replaces them.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_result_sr <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                GET_A:   if (i_rx_done) r_alu_a  <= BUS'($signed(i_rx_data));
                GET_B:   if (i_rx_done) r_alu_b  <= BUS'($signed(i_rx_data));
                GET_OP:  if (i_rx_done) r_alu_op <= i_rx_data;
                EXEC: begin
                    r_result_sr <= i_alu_result;
                    r_cnt       <= NBYTES;
                end
                WAIT_TX: if (i_tx_done) begin
                    r_result_sr <= r_result_sr >> 8;
                    r_cnt       <= r_cnt - LAST;
                end
                default: ;
            endcase
        end
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_tx_data  = r_result_sr[7:0];
    assign o_tx_start = w_tx_start;
    assign o_busy     = w_busy;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench: BUS=8 and BUS=16 sequencers driven in lockstep, each with a reference ALU
// and a UART TX responder; transmitted bytes are checked against expected-byte queues.
module tb_uart_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        td8_r, td16_r, spur_td;
    logic        td8, td16;

    logic [7:0]  a8, b8, op8, txd8, res8;
    logic        txs8, busy8;
    logic [15:0] a16, b16, res16;
    logic [7:0]  op16, txd16;
    logic        txs16, busy16;
    logic [31:0] full8, full16;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] q8[$];
    logic [7:0] q16[$];

    always #5 clk = ~clk;

    assign td8  = td8_r | spur_td;
    assign td16 = td16_r | spur_td;

    uart_alu_sequencer #(.BUS(8)) u8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(res8), .o_alu_a(a8), .o_alu_b(b8), .o_alu_op(op8),
        .o_tx_data(txd8), .o_tx_start(txs8), .i_tx_done(td8), .o_busy(busy8)
    );

    uart_alu_sequencer #(.BUS(16)) u16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(res16), .o_alu_a(a16), .o_alu_b(b16), .o_alu_op(op16),
        .o_tx_data(txd16), .o_tx_start(txs16), .i_tx_done(td16), .o_busy(busy16)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] op);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h03:   return sa >>> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    always_comb full8  = alu_ref({{24{a8[7]}}, a8}, {{24{b8[7]}}, b8}, op8);
    always_comb full16 = alu_ref({{16{a16[15]}}, a16}, {{16{b16[15]}}, b16}, op16);
    assign res8  = full8[7:0];
    assign res16 = full16[15:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy8 || busy16) && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic pulse_spur();
        spur_td = 1'b1;
        tick();
        spur_td = 1'b0;
        chk("spur_txs8", 32'(txs8), 32'd0);
        chk("spur_busy16", 32'(busy16), 32'd0);
    endtask

    task automatic cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input bit spur);
        logic [31:0] sa, sb, r;
        wait_idle();
        sa = {{24{a[7]}}, a};
        sb = {{24{b[7]}}, b};
        r  = alu_ref(sa, sb, op);
        q8.push_back(r[7:0]);
        q16.push_back(r[7:0]);
        q16.push_back(r[15:8]);
        if (spur) pulse_spur();
        send_byte(a);
        if (spur) pulse_spur();
        send_byte(b);
        if (spur) pulse_spur();
        send_byte(op);
        // cycle k+1: EXEC
        chk("exec_busy8", 32'(busy8), 32'd1);
        chk("exec_busy16", 32'(busy16), 32'd1);
        chk("exec_txs8", 32'(txs8), 32'd0);
        chk("alu_a8", 32'(a8), 32'(sa[7:0]));
        chk("alu_a16", 32'(a16), 32'(sa[15:0]));
        chk("alu_b16", 32'(b16), 32'(sb[15:0]));
        chk("alu_op8", 32'(op8), 32'(op));
        tick();
        // cycle k+2: first byte out
        chk("first_txs8", 32'(txs8), 32'd1);
        chk("first_txs16", 32'(txs16), 32'd1);
    endtask

    // TX monitors: pop expected bytes on each tx_start, and never accept back-to-back pulses.
    initial begin
        logic prev8 = 1'b0, prev16 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("tx_dbl8", 32'(prev8 & txs8), 32'd0);
                chk("tx_dbl16", 32'(prev16 & txs16), 32'd0);
                if (txs8) begin
                    chk("tx_q8", 32'(q8.size() > 0), 32'd1);
                    if (q8.size() > 0) chk("tx_data8", 32'(txd8), 32'(q8.pop_front()));
                end
                if (txs16) begin
                    chk("tx_q16", 32'(q16.size() > 0), 32'd1);
                    if (q16.size() > 0) chk("tx_data16", 32'(txd16), 32'(q16.pop_front()));
                end
            end
            prev8  = txs8;
            prev16 = txs16;
        end
    end

    // TX responders: tx_done three cycles after tx_start, then check the follow-up cycle.
    initial begin
        td8_r = 1'b0;
        forever begin
            @(negedge clk);
            if (txs8) begin
                repeat (3) @(posedge clk);
                #1 td8_r = 1'b1;
                @(posedge clk);
                #1 td8_r = 1'b0;
                if (q8.size() > 0) chk("next_txs8", 32'(txs8), 32'd1);
                else               chk("busy_drop8", 32'(busy8), 32'd0);
            end
        end
    end

    initial begin
        td16_r = 1'b0;
        forever begin
            @(negedge clk);
            if (txs16) begin
                repeat (3) @(posedge clk);
                #1 td16_r = 1'b1;
                @(posedge clk);
                #1 td16_r = 1'b0;
                if (q16.size() > 0) chk("next_txs16", 32'(txs16), 32'd1);
                else                chk("busy_drop16", 32'(busy16), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        spur_td = 1'b0;
        tick();
        tick();
        chk("rst_alu_a16", 32'(a16), 32'd0);
        chk("rst_alu_op8", 32'(op8), 32'd0);
        chk("rst_txd16", 32'(txd16), 32'd0);
        chk("rst_txs8", 32'(txs8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD with spurious tx_done in every GET state
        cmd(8'h05, 8'h03, 8'h20, 1'b1);

        // SRA: negative operand sign-extends, 16-bit result streams as two bytes
        cmd(8'hF0, 8'h02, 8'h03, 1'b0);

        // rx byte during WAIT_TX is dropped
        cmd(8'h0F, 8'h01, 8'h22, 1'b0);
        tick();
        send_byte(8'hAA);
        chk("drop_alu_a8", 32'(a8), 32'h0F);
        chk("drop_alu_a16", 32'(a16), 32'h000F);
        chk("drop_busy8", 32'(busy8), 32'd1);
        chk("drop_op16", 32'(op16), 32'h22);
        cmd(8'h01, 8'h01, 8'h20, 1'b0);

        // reset mid-command discards partial operands
        wait_idle();
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_alu_a8", 32'(a8), 32'd0);
        chk("mid_alu_b16", 32'(b16), 32'd0);
        chk("mid_alu_op16", 32'(op16), 32'd0);
        chk("mid_txs16", 32'(txs16), 32'd0);
        chk("mid_busy16", 32'(busy16), 32'd0);
        cmd(8'h01, 8'h02, 8'h25, 1'b0);

        // unknown opcode transmits zero
        cmd(8'h07, 8'h07, 8'hFF, 1'b0);

        wait_idle();
        tick();
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Command sequencer that sits directly upstream of the ALU and between it and the UART. It collects three received bytes: operand A, operand B and the opcode. It drives them onto the ALU operand/opcode inputs, captures the ALU result one cycle later and streams the result back out through the UART transmitter, least-significant byte first. It is the only block that drives the ALU inputs.

## Interface
- BUS, 8, ALU data width; must be a multiple of 8, valid range 8..32
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- rx_data  in  8  byte from UART receiver, valid when rx_done=1
- rx_done  in  1  single-cycle pulse, new byte on rx_data
- alu_result  in  BUS  combinational ALU output
- alu_a  out  BUS  operand A to ALU, sign-extended byte
- alu_b  out  BUS  operand B to ALU, sign-extended byte
- alu_op  out  8  opcode to ALU
- tx_data  out  8  byte to UART transmitter
- tx_start  out  1  single-cycle pulse, transmitter loads tx_data
- tx_done  in  1  single-cycle pulse, transmitter finished a byte
- busy  out  1  high from opcode capture until last result byte done

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- GET_A: on rx_done, alu_a <= sign-extend(rx_data) to BUS bits; go to GET_B.
- GET_B: on rx_done, alu_b <= sign-extend(rx_data); go to GET_OP.
- GET_OP: on rx_done, alu_op <= rx_data; go to EXEC.
- EXEC: one cycle. ALU inputs are stable. At the end of the cycle, result shift register <= alu_result and byte counter <= BUS/8. Go to SEND.
- SEND: one cycle. tx_start=1, tx_data = result_sr[7:0]. Go to WAIT_TX.
- WAIT_TX: on tx_done, result_sr >>= 8 and counter decrements. If the counter was 1, go to GET_A; otherwise go to SEND.
- alu_a, alu_b and alu_op hold their values until overwritten by the next command. They are not cleared after a transaction.
- rx_done in EXEC, SEND or WAIT_TX: the byte is discarded and the state is unchanged. There is no buffering.
- tx_done outside WAIT_TX is ignored.
- busy=1 in EXEC, SEND and WAIT_TX; otherwise 0.
- Unknown opcodes pass through unchanged. The ALU returns 0 for them, and that 0 is transmitted as normal.

## Timing
- Reset: state=GET_A. alu_a=0, alu_b=0, alu_op=0, tx_data=0, tx_start=0, busy=0. Result register and counter are cleared.
- reset_n low mid-transaction: the transaction is abandoned at the next edge. tx_start is 0 in the following cycle, and partial operands are discarded.
- rx_done sampled in cycle k: the matching register is updated and visible from cycle k+1.
- Opcode byte with rx_done in cycle k:
  - EXEC in k+1, with busy=1.
  - alu_result is captured at the end of k+1.
  - tx_start=1 in k+2 with the first result byte.
- tx_done in cycle m, more bytes remaining: tx_start=1 again in m+1.
- tx_done in cycle m, last byte: the state is GET_A and busy=0 in m+1.
- Minimum turnaround: the first byte of the next command is accepted in m+1.
- tx_start is never high for two consecutive cycles.
- rx_done and tx_done in the same cycle while in WAIT_TX: tx_done is processed and the rx byte is dropped.

## Test plan
- BUS=8, bytes 0x05, 0x03, 0x20, ALU instantiated on the outputs:
  - alu_a=0x05, alu_b=0x03, alu_op=0x20.
  - tx_start pulses exactly 2 cycles after the opcode rx_done, with tx_data=0x08.
  - busy drops 1 cycle after tx_done.
- BUS=16, bytes 0xF0, 0x02, 0x03 (SRA):
  - alu_a=0xFFF0.
  - Result 0xFFFC is sent as two bytes, 0xFC then 0xFF, each tx_start one cycle after the previous tx_done.
- BUS=8, command 0x0F, 0x01, 0x22:
  - While in WAIT_TX, inject rx_done with 0xAA: the byte is dropped and the state remains WAIT_TX.
  - After tx_done (tx_data was 0x0E), the next command 0x01, 0x01, 0x20 yields 0x02.
- Reset mid-command: send 0x11, 0x22, then assert reset_n=0 for 1 cycle.
  - All outputs return to 0 at the next edge.
  - A fresh 0x01, 0x02, 0x25 yields tx_data=0x03.
- Unknown opcode: bytes 0x07, 0x07, 0xFF. tx_data=0x00 is transmitted and busy completes normally.
- Spurious tx_done pulses in GET_A, GET_B and GET_OP: no tx_start and no state change.
